// File: rtl/tlul_host_arbiter.sv
// Round-robin arbiter multiplexing several TL-UL hosts onto one device port,
// with at most one transaction outstanding on the device side.
package tlul_pkg;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

module tlul_host_arbiter #(
   parameter int unsigned NumHosts = 3,
   parameter int unsigned HostIdxW = $clog2(NumHosts)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  tlul_pkg::tl_h2d_t tl_h_i [NumHosts],
   output tlul_pkg::tl_d2h_t tl_h_o [NumHosts],
   output tlul_pkg::tl_h2d_t tl_d_o,
   input  tlul_pkg::tl_d2h_t tl_d_i,
   output logic [NumHosts-1:0] grant_o,
   output logic              busy_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [HostIdxW-1:0] grant_q, grant_d;
   logic [HostIdxW-1:0] rr_ptr_q, rr_ptr_d;
   logic [HostIdxW-1:0] next_ptr;
   logic [HostIdxW-1:0] win_idx;
   logic [HostIdxW-1:0] cand_idx;
   logic                win_found;
   int unsigned         cand;
   logic                a_hs, d_hs;
   tlul_pkg::tl_d2h_t   rsp;

   // First requester at or after rr_ptr_q, walking the hosts cyclically.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned k = 0; k < NumHosts; k++) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= NumHosts) cand = cand - NumHosts;
         cand_idx = HostIdxW'(cand);
         if (!win_found && tl_h_i[cand_idx].a_valid) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   assign next_ptr = (int'(grant_q) == NumHosts - 1) ? '0 : grant_q + 1'b1;
   assign a_hs     = tl_h_i[grant_q].a_valid && tl_d_i.a_ready;
   assign d_hs     = tl_d_i.d_valid && tl_h_i[grant_q].d_ready;

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = ADDR;
               grant_d = win_idx;
            end
         end
         ADDR: begin
            if (a_hs) begin
               if (d_hs) begin
                  state_d  = IDLE;
                  grant_d  = '0;
                  rr_ptr_d = next_ptr;
               end else begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            if (d_hs) begin
               state_d  = IDLE;
               grant_d  = '0;
               rr_ptr_d = next_ptr;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // A-channel passes through only in ADDR; D-channel stays routed until the D handshake.
   always_comb begin
      tl_d_o  = '0;
      grant_o = '0;
      for (int unsigned i = 0; i < NumHosts; i++) tl_h_o[i] = '0;
      rsp         = tl_d_i;
      rsp.a_ready = 1'b0;
      if (state_q == ADDR) begin
         tl_d_o      = tl_h_i[grant_q];
         rsp.a_ready = tl_d_i.a_ready;
      end
      if (state_q != IDLE) begin
         tl_d_o.d_ready   = tl_h_i[grant_q].d_ready;
         tl_h_o[grant_q]  = rsp;
         grant_o[grant_q] = 1'b1;
      end
   end

   assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Directed bench for tlul_host_arbiter: transaction-level model checked every cycle
// plus literal expectations for the key scenarios.
module tb_tlul_host_arbiter;
   import tlul_pkg::*;

   localparam int NH = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   tl_h2d_t h [NH];
   tl_d2h_t hr [NH];
   tl_h2d_t dreq;
   tl_d2h_t dev;
   logic [NH-1:0] grant;
   logic busy;

   always #5 clk = ~clk;

   tlul_host_arbiter #(.NumHosts(NH)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .tl_h_i (h),
      .tl_h_o (hr),
      .tl_d_o (dreq),
      .tl_d_i (dev),
      .grant_o(grant),
      .busy_o (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: who owns the port, whether its A beat was taken, whose turn is next.
   int m_owner = -1;
   bit m_acc = 1'b0;
   int m_rr = 0;
   int hist[$];
   int cand;
   bit found;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner = -1;
         m_acc   = 1'b0;
         m_rr    = 0;
      end else if (m_owner < 0) begin
         found = 1'b0;
         for (int k = 0; k < NH; k++) begin
            cand = (m_rr + k) % NH;
            if (!found && h[cand].a_valid) begin
               found   = 1'b1;
               m_owner = cand;
               m_acc   = 1'b0;
               hist.push_back(cand);
            end
         end
      end else begin
         if (!m_acc && h[m_owner].a_valid && dev.a_ready) m_acc = 1'b1;
         else if (m_acc || !(h[m_owner].a_valid && dev.a_ready)) begin end
         if ((m_acc || (h[m_owner].a_valid && dev.a_ready)) && dev.d_valid && h[m_owner].d_ready) begin
            m_rr    = (m_owner + 1) % NH;
            m_owner = -1;
            m_acc   = 1'b0;
         end
      end
   end

   // Handshake counters observed on the wires, compared against literal expectations.
   int a_hs_cnt = 0;
   int d_hs_cnt = 0;
   int host_rx [NH];
   initial for (int i = 0; i < NH; i++) host_rx[i] = 0;

   always @(posedge clk) begin
      if (rst_n) begin
         if (dreq.a_valid && dev.a_ready) a_hs_cnt++;
         if (dev.d_valid && dreq.d_ready) d_hs_cnt++;
         for (int i = 0; i < NH; i++)
            if (hr[i].d_valid && h[i].d_ready) host_rx[i]++;
      end
   end

   logic [NH-1:0] e_grant;
   tl_h2d_t e_d;
   tl_d2h_t e_h [NH];

   always @(negedge clk) begin
      e_grant = '0;
      e_d     = '0;
      for (int i = 0; i < NH; i++) e_h[i] = '0;
      if (m_owner >= 0) begin
         e_grant[m_owner] = 1'b1;
         if (!m_acc) e_d = h[m_owner];
         e_d.d_ready = h[m_owner].d_ready;
         e_h[m_owner] = dev;
         e_h[m_owner].a_ready = m_acc ? 1'b0 : dev.a_ready;
      end
      chk("grant_o", 128'(grant), 128'(e_grant));
      chk("busy_o", 128'(busy), 128'(m_owner >= 0));
      chk("tl_d_o", 128'(dreq), 128'(e_d));
      for (int i = 0; i < NH; i++) chk($sformatf("tl_h_o%0d", i), 128'(hr[i]), 128'(e_h[i]));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic raise(input int host, input logic [31:0] addr);
      h[host].a_valid   = 1'b1;
      h[host].a_opcode  = 3'h4;
      h[host].a_address = addr;
      h[host].a_source  = 8'(8'h10 + host);
      h[host].a_mask    = 4'hF;
      h[host].a_size    = 2'd2;
      h[host].d_ready   = 1'b1;
   endtask

   task automatic serve(input int host, input int a_wait, input int d_hold,
                        input logic [31:0] data, input bit same_cycle);
      int n;
      n = 0;
      while (!grant[host] && n < 20) begin
         cyc();
         n++;
      end
      chk($sformatf("grant_wait%0d", host), 128'(grant[host]), 128'(1));
      dev.a_ready = 1'b0;
      repeat (a_wait) cyc();
      dev.a_ready = 1'b1;
      if (same_cycle) begin
         dev.d_valid    = 1'b1;
         dev.d_data     = data;
         dev.d_opcode   = 3'h1;
         dev.d_source   = h[host].a_source;
         h[host].d_ready = 1'b1;
         cyc();
         dev.a_ready     = 1'b0;
         dev.d_valid     = 1'b0;
         h[host].a_valid = 1'b0;
      end else begin
         cyc();
         dev.a_ready     = 1'b0;
         h[host].a_valid = 1'b0;
         dev.d_valid     = 1'b1;
         dev.d_data      = data;
         dev.d_opcode    = 3'h1;
         dev.d_source    = h[host].a_source;
         h[host].d_ready = 1'b0;
         repeat (d_hold) cyc();
         h[host].d_ready = 1'b1;
         cyc();
         dev.d_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_grant", 128'(grant), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      cyc();
   endtask

   int a0, d0, r0;

   initial begin
      for (int i = 0; i < NH; i++) begin
         h[i] = '0;
         h[i].d_ready = 1'b1;
      end
      dev = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_grant", 128'(grant), 128'(0));
      chk("init_busy", 128'(busy), 128'(0));
      chk("init_tl_d_o", 128'(dreq), 128'(0));
      #3 rst_n = 1'b1;
      cyc();

      // Single request from host1, response one cycle after acceptance.
      hist.delete();
      raise(1, 32'h10);
      dev.a_ready = 1'b1;
      cyc();
      chk("s1_grant", 128'(grant), 128'(3'b010));
      chk("s1_addr", 128'(dreq.a_address), 128'(32'h10));
      cyc();
      h[1].a_valid = 1'b0;
      dev.a_ready  = 1'b0;
      dev.d_valid  = 1'b1;
      dev.d_data   = 32'hA5;
      dev.d_source = 8'h11;
      #1;
      chk("s1_d_data", 128'(hr[1].d_data), 128'(32'hA5));
      chk("s1_d_valid1", 128'(hr[1].d_valid), 128'(1));
      chk("s1_d_valid0", 128'(hr[0].d_valid), 128'(0));
      chk("s1_d_valid2", 128'(hr[2].d_valid), 128'(0));
      cyc();
      dev.d_valid = 1'b0;
      chk("s1_busy_after", 128'(busy), 128'(0));

      // Simultaneous requests from reset are served 0,1,2.
      do_reset();
      hist.delete();
      raise(0, 32'h100);
      raise(1, 32'h104);
      raise(2, 32'h108);
      serve(0, 0, 0, 32'h1, 1'b0);
      serve(1, 1, 0, 32'h2, 1'b0);
      serve(2, 0, 1, 32'h3, 1'b0);
      chk("s2_hist_n", 128'(hist.size()), 128'(3));
      if (hist.size() == 3)
         chk("s2_hist", 128'({hist[0], hist[1], hist[2]}), 128'({32'd0, 32'd1, 32'd2}));

      // Fairness: host0 keeps asking, host2 asks once.
      do_reset();
      hist.delete();
      raise(0, 32'h200);
      cyc();
      raise(2, 32'h208);
      serve(0, 0, 0, 32'h4, 1'b0);
      raise(0, 32'h204);
      serve(2, 0, 0, 32'h5, 1'b0);
      serve(0, 0, 0, 32'h6, 1'b0);
      chk("s3_hist_n", 128'(hist.size()), 128'(3));
      if (hist.size() == 3)
         chk("s3_hist", 128'({hist[0], hist[1], hist[2]}), 128'({32'd0, 32'd2, 32'd0}));

      // Backpressure on both channels: exactly one A and one D handshake.
      a0 = a_hs_cnt;
      d0 = d_hs_cnt;
      r0 = host_rx[1];
      raise(1, 32'h300);
      serve(1, 5, 3, 32'h7, 1'b0);
      chk("s4_a_hs", 128'(a_hs_cnt - a0), 128'(1));
      chk("s4_d_hs", 128'(d_hs_cnt - d0), 128'(1));
      chk("s4_rx1", 128'(host_rx[1] - r0), 128'(1));

      // Host withdraws a_valid before acceptance: grant is held.
      raise(1, 32'h304);
      cyc();
      h[1].a_valid = 1'b0;
      repeat (3) cyc();
      chk("s5_hold_grant", 128'(grant), 128'(3'b010));
      h[1].a_valid = 1'b1;
      serve(1, 0, 0, 32'h8, 1'b0);

      // Same-cycle A+D handshake, then rr_ptr must favour host2 over host0.
      do_reset();
      hist.delete();
      r0 = host_rx[0];
      raise(0, 32'h400);
      serve(0, 0, 0, 32'h9, 1'b1);
      chk("s6_busy", 128'(busy), 128'(0));
      chk("s6_rx0", 128'(host_rx[0] - r0), 128'(1));
      raise(0, 32'h404);
      raise(2, 32'h408);
      serve(2, 0, 0, 32'hA, 1'b0);
      serve(0, 0, 0, 32'hB, 1'b0);
      chk("s6_hist_n", 128'(hist.size()), 128'(3));
      if (hist.size() == 3)
         chk("s6_hist", 128'({hist[0], hist[1], hist[2]}), 128'({32'd0, 32'd2, 32'd0}));

      // Reset while host2 waits in RESP; a late response must not reach anyone.
      hist.delete();
      raise(2, 32'h500);
      dev.a_ready = 1'b1;
      cyc();
      cyc();
      dev.a_ready  = 1'b0;
      h[2].a_valid = 1'b0;
      cyc();
      chk("s7_resp_grant", 128'(grant), 128'(3'b100));
      #2 rst_n = 1'b0;
      #1;
      chk("s7_rst_grant", 128'(grant), 128'(0));
      chk("s7_rst_busy", 128'(busy), 128'(0));
      chk("s7_rst_tl_h_o2", 128'(hr[2]), 128'(0));
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      r0 = host_rx[2];
      dev.d_valid  = 1'b1;
      dev.d_data   = 32'hDEAD;
      dev.d_source = 8'h12;
      cyc();
      cyc();
      chk("s7_late_rx2", 128'(host_rx[2] - r0), 128'(0));
      chk("s7_late_busy", 128'(busy), 128'(0));
      dev.d_valid = 1'b0;
      hist.delete();
      raise(0, 32'h600);
      raise(2, 32'h604);
      serve(0, 0, 0, 32'hC, 1'b0);
      serve(2, 0, 0, 32'hD, 1'b0);
      chk("s7_hist_n", 128'(hist.size()), 128'(2));
      if (hist.size() == 2)
         chk("s7_first", 128'(hist[0]), 128'(0));

      repeat (2) cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

endmodule

// File: doc/tlul_host_arbiter.md
TLUL_HOST_ARBITER -- requirements
Module: tlul_host_arbiter

Interface
REQ-001 SHALL have parameter NumHosts, default 3, number of TL-UL hosts sharing one device port (legal 2..8).
REQ-002 SHALL have parameter HostIdxW, default $clog2(NumHosts), width of the grant index.
REQ-003 SHALL have port clk_i  input  1  system clock; one clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port tl_h_i  input  NumHosts x tlul_pkg::tl_h2d_t  host-side A-channel requests and d_ready.
REQ-006 SHALL have port tl_h_o  output  NumHosts x tlul_pkg::tl_d2h_t  host-side D-channel responses and a_ready.
REQ-007 SHALL have port tl_d_o  output  tlul_pkg::tl_h2d_t  device-side request (e.g. shared simple_uart).
REQ-008 SHALL have port tl_d_i  input  tlul_pkg::tl_d2h_t  device-side response.
REQ-009 SHALL have port grant_o  output  NumHosts  one-hot owner of the device port, all-zero when idle.
REQ-010 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, ADDR, RESP; at most one transaction outstanding on the device port.
REQ-012 IDLE: if any tl_h_i[i].a_valid, SHALL register grant to first requester at or after rr_ptr (cyclic order), go to ADDR next cycle; else stay IDLE.
REQ-013 Arbitration latency SHALL be exactly one cycle: host a_valid at cycle t in IDLE -> tl_d_o.a_valid at t+1.
REQ-014 ADDR: tl_d_o SHALL equal tl_h_i[grant] field-for-field (a_source unmodified); tl_h_o[grant].a_ready SHALL equal tl_d_i.a_ready.
REQ-015 ADDR: on a_valid && a_ready, SHALL go to RESP unless the D handshake completes in the same cycle, then IDLE.
REQ-016 ADDR and RESP: tl_h_o[grant] D fields SHALL equal tl_d_i D fields; tl_d_o.d_ready SHALL equal tl_h_i[grant].d_ready.
REQ-017 RESP: on tl_d_i.d_valid && tl_d_o.d_ready, SHALL go to IDLE; otherwise hold grant indefinitely (no timeout).
REQ-018 Grant SHALL stay stable from entry to ADDR until D handshake; new requests meanwhile SHALL NOT change grant.
REQ-019 On return to IDLE, rr_ptr SHALL become (grant+1) mod NumHosts; winning host becomes lowest priority.
REQ-020 Non-granted hosts, and all hosts in IDLE, SHALL see tl_h_o all-zero (a_ready=0, d_valid=0).
REQ-021 In IDLE tl_d_o SHALL be all-zero (a_valid=0, d_ready=0).
REQ-022 tl_d_i.d_valid in IDLE (protocol violation) SHALL be ignored, no state change.
REQ-023 A host dropping a_valid in ADDR before acceptance SHALL not cause deadlock: grant held until accepted (protocol violation, behaviour otherwise undefined).
REQ-024 Back-to-back: earliest re-grant one cycle after D handshake (IDLE visited for one cycle).

Reset
REQ-025 Async reset assertion SHALL force state IDLE, rr_ptr=0, grant=0 immediately, independent of clk_i.
REQ-026 During and after reset: grant_o=0, busy_o=0, tl_h_o all-zero, tl_d_o all-zero until first grant.
REQ-027 Reset mid-transaction SHALL discard it; no response forwarded to any host afterwards.
REQ-028 Reset deassertion SHALL be synchronous-safe; first arbitration no earlier than first clk_i edge after release.

Verification
REQ-029 Single request: host1 Get addr 0x10, device a_ready=1, responds next cycle data 0xA5 -> grant_o=3'b010 at t+1, host1 gets d_data 0xA5, hosts 0/2 d_valid=0, busy_o low after handshake.
REQ-030 Simultaneous: hosts 0,1,2 assert a_valid same cycle from reset -> served in order 0,1,2, grant_o 001,010,100, each held to its D handshake.
REQ-031 Fairness: host0 continuously requesting, host2 requests once -> grant sequence 0,2,0; host2 never waits more than one transaction.
REQ-032 Backpressure: device a_ready low 5 cycles, then d_ready held low 3 cycles by host -> grant and tl_d_o stable throughout, single A and D handshake each.
REQ-033 Reset mid-RESP: assert rst_ni low while host2 waits -> grant_o=0, busy_o=0 same cycle; late device d_valid after release not forwarded; next request from host0 granted first.
REQ-034 Same-cycle A+D handshake in ADDR -> IDLE next cycle, rr_ptr advanced, exactly one response delivered.
